// File: rtl/menu_text_overlay.sv
// Text overlay for a video stream: a menu of N_PAGES entries with a highlighted
// cursor row, and one full text page per entry. Keys move the cursor, open a page
// and return to the menu. The visible selection only changes at frame start, so a
// frame is never drawn half in one mode and half in another. Video timing and rgb
// take 3 cycles from in_* to out_*; the text buffer and font ROM lookup fit inside
// that delay.
module menu_text_overlay #(
  parameter int          N_PAGES   = 4,
  parameter int          MENU_X0   = 200,
  parameter int          MENU_Y0   = 100,
  parameter int          MENU_COLS = 16,
  parameter int          MENU_ROWS = 8,
  parameter int          PAGE_X0   = 100,
  parameter int          PAGE_Y0   = 100,
  parameter int          PAGE_COLS = 64,
  parameter int          PAGE_ROWS = 8,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter logic [3:0]  KEY_UP    = 4'h1,
  parameter logic [3:0]  KEY_DOWN  = 4'h2,
  parameter logic [3:0]  KEY_ENTER = 4'h3,
  parameter logic [3:0]  KEY_ESC   = 4'hF,
  localparam int MC_W  = $clog2(MENU_COLS),
  localparam int MR_W  = $clog2(MENU_ROWS),
  localparam int PC_W  = $clog2(PAGE_COLS),
  localparam int PR_W  = $clog2(PAGE_ROWS),
  localparam int CXY_W = (MC_W + MR_W > PC_W + PR_W) ? (MC_W + MR_W) : (PC_W + PR_W),
  localparam int SEL_W = $clog2(N_PAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       key,
  input  logic             key_valid,
  input  logic [10:0]      in_hcount,
  input  logic [10:0]      in_vcount,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic             in_hblnk,
  input  logic             in_vblnk,
  input  logic [11:0]      in_rgb,
  output logic [10:0]      out_hcount,
  output logic [10:0]      out_vcount,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic             out_hblnk,
  output logic             out_vblnk,
  output logic [11:0]      out_rgb,
  output logic [CXY_W-1:0] char_xy,
  output logic [3:0]       char_line,
  input  logic [7:0]       char_line_pixels,
  output logic [SEL_W-1:0] text_sel,
  output logic [2:0]       cursor
);

  typedef enum logic {MENU, PAGE} mode_t;

  localparam logic [2:0]  LAST = 3'(N_PAGES - 1);
  // Window bounds are 12 bits wide so X0 + 8*COLS can reach 2048 without wrapping.
  localparam logic [11:0] MX0 = 12'(MENU_X0);
  localparam logic [11:0] MX1 = 12'(MENU_X0 + 8 * MENU_COLS);
  localparam logic [11:0] MY0 = 12'(MENU_Y0);
  localparam logic [11:0] MY1 = 12'(MENU_Y0 + 16 * MENU_ROWS);
  localparam logic [11:0] PX0 = 12'(PAGE_X0);
  localparam logic [11:0] PX1 = 12'(PAGE_X0 + 8 * PAGE_COLS);
  localparam logic [11:0] PY0 = 12'(PAGE_Y0);
  localparam logic [11:0] PY1 = 12'(PAGE_Y0 + 16 * PAGE_ROWS);

  mode_t      mode_q, mode_d;
  logic [2:0] page_q, page_d, cur_q, cur_d;
  logic       disp_page;
  logic       frame_start;

  logic [11:0] hx, vy;
  logic [10:0] mdx, mdy, pdx, pdy;
  logic        unused_bits;

  logic             win_c, hl_c;
  logic [2:0]       bit_c;
  logic [CXY_W-1:0] xy_c;
  logic [3:0]       line_c;

  // Timing bundle: {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}
  logic [37:0] tim1, tim2;
  logic        win1, win2, hl1, hl2;
  logic [2:0]  bit1, bit2;
  logic        pix_on;

  assign frame_start = (in_hcount == 11'd0) && (in_vcount == 11'd0);

  // Requested-state register (what the user has selected so far).
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MENU;
      page_q <= 3'd0;
      cur_q  <= 3'd0;
    end else begin
      mode_q <= mode_d;
      page_q <= page_d;
      cur_q  <= cur_d;
    end
  end

  // Key handling: next requested state; unknown keys and idle cycles hold state.
  always_comb begin
    mode_d = mode_q;
    page_d = page_q;
    cur_d  = cur_q;
    if (key_valid) begin
      case (mode_q)
        MENU: begin
          if (key == KEY_DOWN) begin
            cur_d = (cur_q == LAST) ? 3'd0 : cur_q + 3'd1;
          end else if (key == KEY_UP) begin
            cur_d = (cur_q == 3'd0) ? LAST : cur_q - 3'd1;
          end else if (key == KEY_ENTER) begin
            mode_d = PAGE;
            page_d = cur_q;
          end
        end
        PAGE: begin
          if (key == KEY_ESC) mode_d = MENU;
        end
        default: mode_d = MENU;
      endcase
    end
  end

  // Displayed state: sampled from the pre-key requested state at frame start only.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_page <= 1'b0;
      cursor    <= 3'd0;
      text_sel  <= '0;
    end else if (frame_start) begin
      disp_page <= (mode_q == PAGE);
      cursor    <= cur_q;
      text_sel  <= (mode_q == PAGE) ? SEL_W'(4'(page_q) + 4'd1) : '0;
    end
  end

  assign hx  = {1'b0, in_hcount};
  assign vy  = {1'b0, in_vcount};
  assign mdx = in_hcount - MX0[10:0];
  assign mdy = in_vcount - MY0[10:0];
  assign pdx = in_hcount - PX0[10:0];
  assign pdy = in_vcount - PY0[10:0];
  assign unused_bits = ^{mdx, mdy, pdx, pdy};

  // Window hit test and text-buffer address for the current input pixel.
  always_comb begin
    win_c  = 1'b0;
    hl_c   = 1'b0;
    bit_c  = 3'd0;
    xy_c   = '0;
    line_c = 4'd0;
    if (!disp_page) begin
      if (hx >= MX0 && hx < MX1 && vy >= MY0 && vy < MY1) begin
        win_c  = 1'b1;
        xy_c   = CXY_W'({mdy[MR_W+3:4], mdx[MC_W+2:3]});
        line_c = mdy[3:0];
        bit_c  = mdx[2:0];
        hl_c   = (mdy[MR_W+3:4] == MR_W'(cursor));
      end
    end else begin
      if (hx >= PX0 && hx < PX1 && vy >= PY0 && vy < PY1) begin
        win_c  = 1'b1;
        xy_c   = CXY_W'({pdy[PR_W+3:4], pdx[PC_W+2:3]});
        line_c = pdy[3:0];
        bit_c  = pdx[2:0];
      end
    end
  end

  // Stage 1: issue the glyph lookup and delay timing while the ROM responds.
  always_ff @(posedge clk) begin
    if (rst) begin
      tim1      <= '0;
      win1      <= 1'b0;
      hl1       <= 1'b0;
      bit1      <= 3'd0;
      char_xy   <= '0;
      char_line <= 4'd0;
    end else begin
      tim1      <= {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk, in_rgb};
      win1      <= win_c;
      hl1       <= hl_c;
      bit1      <= bit_c;
      char_xy   <= xy_c;
      char_line <= line_c;
    end
  end

  // Stage 2: align pixel-decision flags with the glyph row arriving from the ROM.
  always_ff @(posedge clk) begin
    if (rst) begin
      tim2 <= '0;
      win2 <= 1'b0;
      hl2  <= 1'b0;
      bit2 <= 3'd0;
    end else begin
      tim2 <= tim1;
      win2 <= win1;
      hl2  <= hl1;
      bit2 <= bit1;
    end
  end

  assign pix_on = char_line_pixels[3'd7 - bit2] ^ hl2;

  // Output stage: draw text inside the window, pass video through elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk} <= '0;
      out_rgb <= 12'd0;
    end else begin
      {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk} <= tim2[37:12];
      if (win2 && !tim2[13] && !tim2[12]) out_rgb <= pix_on ? FG_COLOR : BG_COLOR;
      else                                out_rgb <= tim2[11:0];
    end
  end

endmodule

// File: tb/tb_menu_text_overlay.sv
// Directed bench for menu_text_overlay with default parameters. The font ROM model
// answers every lookup with 8'hA5 one cycle later. Each tick drives one pixel and
// records what the output should be 3 cycles later.
module tb_menu_text_overlay;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key = 4'h0;
  logic        key_valid = 1'b0;
  logic [10:0] in_hcount = '0, in_vcount = '0;
  logic        in_hsync = 1'b0, in_vsync = 1'b0, in_hblnk = 1'b0, in_vblnk = 1'b0;
  logic [11:0] in_rgb = '0;
  logic [10:0] out_hcount, out_vcount;
  logic        out_hsync, out_vsync, out_hblnk, out_vblnk;
  logic [11:0] out_rgb;
  logic [8:0]  char_xy;
  logic [3:0]  char_line;
  logic [7:0]  char_line_pixels;
  logic [2:0]  text_sel;
  logic [2:0]  cursor;

  int n_chk = 0;
  int n_fail = 0;
  int run = 0;

  logic [10:0] hq[3];
  logic [10:0] vq[3];
  logic [3:0]  sq[3];
  logic [1:0]  mq[3];
  logic [11:0] eq[3];

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;
  logic [11:0] hl_pat[8] = '{BG, FG, BG, FG, FG, BG, FG, BG};

  menu_text_overlay dut (
    .clk(clk), .rst(rst), .key(key), .key_valid(key_valid),
    .in_hcount(in_hcount), .in_vcount(in_vcount), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_hblnk(in_hblnk), .in_vblnk(in_vblnk), .in_rgb(in_rgb),
    .out_hcount(out_hcount), .out_vcount(out_vcount), .out_hsync(out_hsync),
    .out_vsync(out_vsync), .out_hblnk(out_hblnk), .out_vblnk(out_vblnk), .out_rgb(out_rgb),
    .char_xy(char_xy), .char_line(char_line), .char_line_pixels(char_line_pixels),
    .text_sel(text_sel), .cursor(cursor)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) char_line_pixels <= 8'hA5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: no rgb check, 1: pass-through expected, 2: expect colour ex
  task automatic tick(input logic [10:0] h, input logic [10:0] v, input logic hb,
                      input logic [1:0] mode, input logic [11:0] ex);
    logic vb;
    @(negedge clk);
    vb = (v >= 11'd600);
    in_hcount = h;
    in_vcount = v;
    in_hsync  = h[1];
    in_vsync  = v[1];
    in_hblnk  = hb;
    in_vblnk  = vb;
    in_rgb    = {v[3:0], h[7:0]};
    for (int i = 2; i > 0; i--) begin
      hq[i] = hq[i-1]; vq[i] = vq[i-1]; sq[i] = sq[i-1]; mq[i] = mq[i-1]; eq[i] = eq[i-1];
    end
    hq[0] = h; vq[0] = v; sq[0] = {h[1], v[1], hb, vb}; mq[0] = mode;
    eq[0] = (mode == 2'd1) ? {v[3:0], h[7:0]} : ex;
    @(posedge clk);
    #1;
    if (rst) run = 0;
    else     run++;
    if (run >= 3) begin
      check("out_hcount", 32'(out_hcount), 32'(hq[2]));
      check("out_vcount", 32'(out_vcount), 32'(vq[2]));
      check("sync_blank", 32'({out_hsync, out_vsync, out_hblnk, out_vblnk}), 32'(sq[2]));
      if (mq[2] != 2'd0) check("out_rgb", 32'(out_rgb), 32'(eq[2]));
    end
  endtask

  task automatic frame();
    tick(11'd0, 11'd0, 1'b0, 2'd1, 12'h0);
  endtask

  task automatic press(input logic [3:0] k);
    key = k;
    key_valid = 1'b1;
    tick(11'd5, 11'd3, 1'b0, 2'd1, 12'h0);
    key_valid = 1'b0;
  endtask

  task automatic flush();
    tick(11'd20, 11'd4, 1'b0, 2'd1, 12'h0);
    tick(11'd21, 11'd4, 1'b0, 2'd1, 12'h0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      hq[i] = '0; vq[i] = '0; sq[i] = '0; mq[i] = '0; eq[i] = '0;
    end

    // Reset state
    tick(11'd300, 11'd150, 1'b0, 2'd0, 12'h0);
    tick(11'd301, 11'd150, 1'b0, 2'd0, 12'h0);
    check("rst_rgb", 32'(out_rgb), 32'h0);
    check("rst_hcount", 32'(out_hcount), 32'h0);
    check("rst_char_xy", 32'(char_xy), 32'h0);
    check("rst_text_sel", 32'(text_sel), 32'h0);
    check("rst_cursor", 32'(cursor), 32'h0);
    rst = 1'b0;

    // Three idle frames: pass-through outside the window
    for (int f = 0; f < 3; f++) begin
      frame();
      for (int i = 1; i <= 6; i++) tick(11'(i * 7), 11'd2, (i == 3), 2'd1, 12'h0);
      tick(11'd50, 11'd700, 1'b0, 2'd1, 12'h0);
      check("idle_text_sel", 32'(text_sel), 32'h0);
      check("idle_cursor", 32'(cursor), 32'h0);
    end

    // Menu geometry and rendering, cursor on row 0
    tick(11'd225, 11'd120, 1'b0, 2'd2, BG);
    check("menu_xy", 32'(char_xy), 32'd19);
    check("menu_line", 32'(char_line), 32'd4);
    tick(11'd327, 11'd120, 1'b0, 2'd2, FG);
    check("menu_xy_right", 32'(char_xy), 32'd31);
    tick(11'd328, 11'd120, 1'b0, 2'd1, 12'h0);
    check("menu_xy_out_x", 32'(char_xy), 32'd0);
    check("menu_line_out_x", 32'(char_line), 32'd0);
    tick(11'd200, 11'd227, 1'b0, 2'd2, FG);
    check("menu_xy_bottom", 32'(char_xy), 32'd112);
    check("menu_line_bottom", 32'(char_line), 32'd15);
    tick(11'd200, 11'd228, 1'b0, 2'd1, 12'h0);
    check("menu_xy_out_y", 32'(char_xy), 32'd0);
    tick(11'd199, 11'd150, 1'b0, 2'd1, 12'h0);
    tick(11'd200, 11'd100, 1'b0, 2'd2, BG);
    tick(11'd201, 11'd100, 1'b0, 2'd2, FG);
    tick(11'd210, 11'd120, 1'b1, 2'd1, 12'h0);
    flush();

    // Cursor movement
    press(4'h2); check("cur_hold", 32'(cursor), 32'd0);
    frame();     check("cur_down1", 32'(cursor), 32'd1);
    press(4'h2); frame(); check("cur_down2", 32'(cursor), 32'd2);
    press(4'h2); frame(); check("cur_down3", 32'(cursor), 32'd3);
    press(4'h1); check("cur_hold_up", 32'(cursor), 32'd3);
    frame();     check("cur_up", 32'(cursor), 32'd2);
    press(4'h7);
    key = 4'h2;
    tick(11'd6, 11'd3, 1'b0, 2'd1, 12'h0);
    press(4'hF);
    frame();     check("cur_ignored", 32'(cursor), 32'd2);
    check("sel_ignored", 32'(text_sel), 32'd0);

    // Key on the frame-start cycle lands one frame later
    key = 4'h2;
    key_valid = 1'b1;
    frame();
    key_valid = 1'b0;
    check("fs_key_pre", 32'(cursor), 32'd2);
    frame();     check("fs_key_post", 32'(cursor), 32'd3);
    press(4'h2); frame(); check("wrap_down", 32'(cursor), 32'd0);
    press(4'h1); frame(); check("wrap_up", 32'(cursor), 32'd3);
    press(4'h2); press(4'h2); press(4'h2);
    frame();     check("cur_back2", 32'(cursor), 32'd2);

    // Highlighted cursor row with glyph 8'hA5
    for (int i = 0; i < 8; i++) tick(11'(200 + i), 11'd135, 1'b0, 2'd2, hl_pat[i]);
    tick(11'd200, 11'd120, 1'b0, 2'd2, FG);
    flush();

    // Enter page 2 mid-frame
    press(4'h3);
    tick(11'd300, 11'd150, 1'b0, 2'd0, 12'h0);
    check("enter_hold", 32'(text_sel), 32'd0);
    frame();
    check("enter_sel", 32'(text_sel), 32'd3);
    check("enter_cursor", 32'(cursor), 32'd2);
    tick(11'd143, 11'd139, 1'b0, 2'd2, BG);
    check("page_xy", 32'(char_xy), 32'd133);
    check("page_line", 32'(char_line), 32'd7);
    tick(11'd611, 11'd139, 1'b0, 2'd2, FG);
    check("page_xy_right", 32'(char_xy), 32'd191);
    tick(11'd612, 11'd139, 1'b0, 2'd1, 12'h0);
    check("page_xy_out", 32'(char_xy), 32'd0);
    tick(11'd100, 11'd139, 1'b0, 2'd2, FG);
    tick(11'd105, 11'd139, 1'b0, 2'd2, FG);
    tick(11'd99, 11'd139, 1'b0, 2'd1, 12'h0);
    flush();

    // UP ignored in page, ESC returns to menu
    press(4'h1);
    press(4'hF);
    check("esc_hold", 32'(text_sel), 32'd3);
    frame();
    check("esc_sel", 32'(text_sel), 32'd0);
    check("esc_cursor", 32'(cursor), 32'd2);

    // Reset pulse during an active page line
    press(4'h3);
    frame();
    check("reenter_sel", 32'(text_sel), 32'd3);
    tick(11'd150, 11'd140, 1'b0, 2'd2, FG);
    tick(11'd151, 11'd140, 1'b0, 2'd2, BG);
    tick(11'd152, 11'd140, 1'b0, 2'd2, BG);
    rst = 1'b1;
    tick(11'd160, 11'd140, 1'b0, 2'd0, 12'h0);
    rst = 1'b0;
    check("mid_rst_rgb", 32'(out_rgb), 32'h0);
    check("mid_rst_hcount", 32'(out_hcount), 32'h0);
    check("mid_rst_xy", 32'(char_xy), 32'h0);
    check("mid_rst_line", 32'(char_line), 32'h0);
    check("mid_rst_sel", 32'(text_sel), 32'h0);
    check("mid_rst_cursor", 32'(cursor), 32'h0);
    for (int i = 0; i < 4; i++) tick(11'(170 + i), 11'd140, 1'b0, 2'd1, 12'h0);
    check("post_rst_xy", 32'(char_xy), 32'h0);
    frame();
    check("post_rst_sel", 32'(text_sel), 32'h0);
    check("post_rst_cursor", 32'(cursor), 32'h0);
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/menu_text_overlay.md
MENU_TEXT_OVERLAY -- requirements
Module: menu_text_overlay

Interface
REQ-001 Parameter N_PAGES, default 4, number of selectable text pages (2..8).
REQ-002 Parameter MENU_X0/MENU_Y0, default 200/100, menu window top-left pixel; MENU_COLS/MENU_ROWS, default 16/8, menu size in characters (powers of two, MENU_ROWS >= N_PAGES).
REQ-003 Parameter PAGE_X0/PAGE_Y0, default 100/100, page window top-left pixel; PAGE_COLS/PAGE_ROWS, default 64/8, page size in characters (powers of two).
REQ-004 Parameters FG_COLOR, default 12'hFFF, and BG_COLOR, default 12'h000, 12-bit text colours; KEY_UP/KEY_DOWN/KEY_ENTER/KEY_ESC, defaults 4'h1/4'h2/4'h3/4'hF, key codes.
REQ-005 Derived: CXY_W = max(log2(MENU_COLS)+log2(MENU_ROWS), log2(PAGE_COLS)+log2(PAGE_ROWS)); SEL_W = clog2(N_PAGES+1).
REQ-006 clk  in  1  pixel clock.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 key  in  4  key code, sampled only when key_valid is high.
REQ-009 key_valid  in  1  single-cycle key strobe.
REQ-010 in_hcount/in_vcount  in  11/11  input timing counters; in_hsync, in_vsync, in_hblnk, in_vblnk  in  1 each; in_rgb  in  12.
REQ-011 out_hcount/out_vcount  out  11/11; out_hsync, out_vsync, out_hblnk, out_vblnk  out  1 each; out_rgb  out  12; all registered.
REQ-012 char_xy  out  CXY_W  {row, col} address into the text buffer, registered.
REQ-013 char_line  out  4  glyph line 0..15, registered.
REQ-014 char_line_pixels  in  8  glyph row from the font ROM; bit 7 is the leftmost pixel; arrives exactly 1 cycle after char_xy/char_line.
REQ-015 text_sel  out  SEL_W  0 = menu, k+1 = page k; registered.
REQ-016 cursor  out  3  displayed menu cursor row, registered.

Function
REQ-017 Requested state: mode (MENU/PAGE), page index, cursor; updated only on cycles with key_valid=1.
REQ-018 In MENU, KEY_DOWN: cursor+1, wrapping N_PAGES-1 -> 0; KEY_UP: cursor-1, wrapping 0 -> N_PAGES-1.
REQ-019 In MENU, KEY_ENTER: mode=PAGE, page=cursor.
REQ-020 In PAGE, KEY_ESC: mode=MENU with cursor unchanged; all other keys ignored.
REQ-021 Unlisted key codes: ignored in every mode; key_valid=0: key ignored.
REQ-022 Displayed state (drives rendering, text_sel and cursor) copies requested state only on the cycle with in_hcount==0 and in_vcount==0, so there is no mid-frame switching.
REQ-023 Key event on that same cycle: the displayed state takes the pre-key value; the key takes effect at the next frame start.
REQ-024 Window membership uses the displayed mode and input counters: x in [X0, X0+8*COLS), y in [Y0, Y0+16*ROWS).
REQ-025 Inside window: col=(x-X0)>>3, row=(y-Y0)>>4, char_line=(y-Y0)[3:0], char_xy={row,col}, with unused MSBs zero.
REQ-026 Outside window: char_xy=0 and char_line=0.
REQ-027 Pixel rendering inside window: bit char_line_pixels[7-((x-X0)%8)] of 1 -> FG_COLOR, 0 -> BG_COLOR.
REQ-028 In MENU, when row == cursor, FG and BG are swapped for that row (highlight).
REQ-029 Outside window, or during hblnk/vblnk: out_rgb = in_rgb delayed.
REQ-030 Fixed latency of 3 cycles from in_* to out_* for all timing signals and rgb, in every mode.
REQ-031 char_xy/char_line lead the pixel decision by 2 cycles; in-window flag, bit index and highlight flag are pipelined to match.
REQ-032 All arithmetic is unsigned 11-bit; window bounds are computed so that X0+8*COLS <= 2047 does not overflow.

Reset
REQ-033 On rst, all outputs, pipeline registers, mode (MENU), page (0) and cursor (0) are reset to 0, both requested and displayed; text_sel=0.
REQ-034 rst asserted mid-frame takes effect next cycle; after release, output is valid after 3 cycles and the displayed state remains MENU until the next frame start.

Verification
REQ-035 Reset, then 3 frames with no keys -> text_sel=0, cursor=0, out_* equal in_* delayed by exactly 3 cycles outside the window.
REQ-036 Three KEY_DOWN events, then KEY_UP with N_PAGES=4 -> requested cursor 1,2,3,2; displayed cursor changes only at frame start; a fourth KEY_DOWN from 3 wraps to 0.
REQ-037 cursor=2, KEY_ENTER mid-frame -> text_sel stays 0 until in_hcount=in_vcount=0, then becomes 3; char_xy follows the page geometry (64 cols).
REQ-038 In PAGE, KEY_UP then KEY_ESC -> UP is ignored; after frame start text_sel=0 and cursor=2.
REQ-039 Font model returns 8'hA5 at pixel (x=MENU_X0..+7, cursor row) -> out_rgb pattern BG,FG,BG,FG,FG,BG,FG,BG (swapped colours).
REQ-040 rst pulse during an active PAGE line -> all outputs are 0 the next cycle; MENU is displayed at the following frame start.
